udp_tx_lb_multi: RTL and testbench
==================================

Name: udp_tx_lb_multi

Overview:
- Parametrised successor to the UDP TX tile's internal output load balancer.
- Sits between the TX NoC-out formatter and the NoC0 val/rdy-to-credit converter.
- Spreads whole outgoing NoC messages round-robin across up to NUM_DSTS destination tiles by rewriting dst X/Y in each header flit; body flits follow their header untouched.
- Destination table is runtime-programmable; the active destination count is runtime-selectable.

Parameters:
- NOC_DATA_W, 512, flit width.
- XY_W, 8, width of the X and Y coordinate fields.
- NUM_DSTS, 4, table depth (power of two, >=2).
- DST_X_LSB, 0, LSB of the dst X field in a header flit.
- DST_Y_LSB, 8, LSB of the dst Y field in a header flit.
- MSG_LEN_LSB, 16, LSB of the body-flit-count field in a header flit.
- MSG_LEN_W, 8, width of the body-flit-count field.
- BASE_X, 1, reset X for table entry i (entry i resets to BASE_X+i).
- BASE_Y, 0, reset Y for all table entries.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- src_udp_tx_lb_val  in  1  input flit valid.
- src_udp_tx_lb_data  in  NOC_DATA_W  input flit.
- udp_tx_lb_src_rdy  out  1  input ready.
- udp_tx_lb_dst_val  out  1  output flit valid.
- udp_tx_lb_dst_data  out  NOC_DATA_W  output flit.
- dst_udp_tx_lb_rdy  in  1  output ready.
- cfg_wr_val  in  1  table write strobe.
- cfg_wr_idx  in  log2(NUM_DSTS)  table entry to write.
- cfg_wr_x  in  XY_W  X value to write.
- cfg_wr_y  in  XY_W  Y value to write.
- cfg_num_active  in  log2(NUM_DSTS)+1  number of active entries (0 is treated as 1; values above NUM_DSTS clamp to NUM_DSTS).
- lb_busy  out  1  high while in BODY state.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Datapath is combinational (latency 0):
  - dst_val = src_val.
  - src_rdy = dst_rdy.
  - A flit transfers when val && rdy on both sides.
  - No valid dependency on ready.
- Reset:
  - state = HDR, rr_ptr = 0, body_cnt = 0, lb_busy = 0.
  - Table entry i = {BASE_Y, BASE_X+i}.
  - Outputs follow src inputs combinationally (dst_val = 0 while src_val = 0).
  - Reset mid-message drops the remainder; the next flit after reset is treated as a header.
- FSM state HDR:
  - Output data = input flit with X field replaced by table[rr_ptr].x and Y field by table[rr_ptr].y.
  - All other bits pass through unchanged.
  - On transfer with len = MSG_LEN field:
    - len == 0: stay in HDR (header-only message).
    - Otherwise: body_cnt <= len, go to BODY.
  - rr_ptr advances only on a header transfer: rr_ptr <= (rr_ptr+1 >= eff_active) ? 0 : rr_ptr+1.
- FSM state BODY:
  - Data passes unmodified.
  - Each transfer decrements body_cnt; the transfer at body_cnt == 1 returns to HDR.
  - lb_busy = 1 in BODY.
- Stall: no state, counter or pointer change without a transfer; data is held stable by the source per val/rdy rules.
- Table writes:
  - Take effect the cycle after cfg_wr_val.
  - A write to the entry currently in use during BODY does not affect the message in flight (only headers are rewritten).
  - A write in the same cycle as a header transfer using that entry: the header gets the old value.
- Pointer vs active count:
  - eff_active is sampled on each header transfer.
  - If rr_ptr >= eff_active (count reduced), the current header uses entry 0 and rr_ptr <= 1 mod eff_active.
- Width: body_cnt is MSG_LEN_W bits; maximum message is 2^MSG_LEN_W-1 body flits; no wrap beyond that.

Optional Feature:
- Macro: UDP_TX_LB_MULTI_STATS_EN.
- When defined:
  - Adds output lb_pkt_cnt (NUM_DSTS*32 bits, entry i at [32i+:32]): per-destination 32-bit header-transfer counters that wrap at 2^32.
  - Counters clear on rst, and also on a cfg_wr_val to that entry.
- When undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package udp_tx_lb_pkg:
  - typedef lb_dst_entry_t {y, x}.
  - State enum lb_state_e {HDR, BODY}.
  - Clamp function for eff_active.
- Sub-module udp_tx_lb_rr_sel: owns the table, rr_ptr, eff_active clamp and pointer advance; outputs the selected entry.
- The top holds the FSM, body counter, field rewrite and optional stats.

Test Plan:
- Default table, num_active=4, four 2-body-flit messages:
  - Headers exit with X = 1,2,3,4, Y = 0.
  - Body flits are bit-identical to input.
  - 12 transfers total.
- num_active=2, five header-only messages (len=0) → X sequence 1,2,1,2,1; lb_busy stays 0.
- dst_rdy toggled 1010… during a 3-body message → no flit lost or duplicated; rr_ptr advances once; FSM returns to HDR after the 3rd body flit.
- Write entry 1 = (9,5) while in BODY of a message using entry 1:
  - In-flight message is unaffected.
  - The next use of entry 1 emits X=9, Y=5.
- num_active reduced from 4 to 2 when rr_ptr=3 → next header uses entry 0; the one after uses entry 1.
- rst asserted mid-body after 1 of 4 body flits → next flit is rewritten as a header using entry 0; with UDP_TX_LB_MULTI_STATS_EN, all lb_pkt_cnt read 0 after reset.

Source files
------------

// File: rtl/udp_tx_lb_pkg.sv
// Shared types and helpers for the UDP TX output load balancer.
// Holds the destination entry layout, the message FSM state encoding and
// the clamp that turns a raw active-destination count into a usable one.
package udp_tx_lb_pkg;

    localparam int LB_XY_W = 8;

    // One destination tile coordinate pair, Y in the upper half.
    typedef struct packed {
        logic [LB_XY_W-1:0] y;
        logic [LB_XY_W-1:0] x;
    } lb_dst_entry_t;

    // HDR: next flit is a header to be rewritten; BODY: flits pass untouched.
    typedef enum logic {
        HDR  = 1'b0,
        BODY = 1'b1
    } lb_state_e;

    // A count of 0 still needs one destination; anything above the table depth
    // is limited to the table depth.
    function automatic int unsigned lb_eff_active(input int unsigned num_active,
                                                  input int unsigned num_dsts);
        if (num_active == 0) begin
            return 1;
        end else if (num_active > num_dsts) begin
            return num_dsts;
        end else begin
            return num_active;
        end
    endfunction

endpackage

// File: rtl/udp_tx_lb_rr_sel.sv
// Destination table and round-robin pointer for the UDP TX load balancer.
// Presents the entry the next header will use; the pointer only moves when
// the parent reports a header transfer (adv).
module udp_tx_lb_rr_sel
    import udp_tx_lb_pkg::*;
#(
    parameter int NUM_DSTS = 4,
    parameter int XY_W     = 8,
    parameter int BASE_X   = 1,
    parameter int BASE_Y   = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    input  logic                        cfg_wr_val,
    input  logic [$clog2(NUM_DSTS)-1:0] cfg_wr_idx,
    input  logic [XY_W-1:0]             cfg_wr_x,
    input  logic [XY_W-1:0]             cfg_wr_y,
    input  logic [$clog2(NUM_DSTS):0]   cfg_num_active,
    output logic [XY_W-1:0]             sel_x,
    output logic [XY_W-1:0]             sel_y,
    output logic [$clog2(NUM_DSTS)-1:0] sel_idx
);

    localparam int IDX_W = $clog2(NUM_DSTS);

    logic [XY_W-1:0]  tbl_x [NUM_DSTS];
    logic [XY_W-1:0]  tbl_y [NUM_DSTS];
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W:0]   eff_active;
    logic [IDX_W:0]   inc_ext;

    // Clamp the active count; a pointer left beyond a shrunken range falls back to entry 0.
    always_comb begin
        eff_active = (IDX_W+1)'(lb_eff_active(32'(cfg_num_active), NUM_DSTS));
        cur_idx    = ({1'b0, rr_ptr} >= eff_active) ? '0 : rr_ptr;
        inc_ext    = {1'b0, cur_idx} + 1'b1;
    end

    // Table storage: reset to a row of tiles starting at BASE_X, writes land next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DSTS; i++) begin
                tbl_x[i] <= XY_W'(BASE_X + i);
                tbl_y[i] <= XY_W'(BASE_Y);
            end
        end else if (cfg_wr_val) begin
            tbl_x[cfg_wr_idx] <= cfg_wr_x;
            tbl_y[cfg_wr_idx] <= cfg_wr_y;
        end
    end

    // Round-robin pointer advances once per header, wrapping at the active count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (adv) begin
            rr_ptr <= (inc_ext >= eff_active) ? '0 : inc_ext[IDX_W-1:0];
        end
    end

    assign sel_x   = tbl_x[cur_idx];
    assign sel_y   = tbl_y[cur_idx];
    assign sel_idx = cur_idx;

endmodule

// File: rtl/udp_tx_lb_multi.sv
// UDP TX output load balancer: spreads whole NoC messages round-robin over
// a programmable set of destination tiles by rewriting dst X/Y in headers.
// The flit path is combinational; only the message framing is registered.
// Optional per-destination header counters: define UDP_TX_LB_MULTI_STATS_EN.
//
// Handshake: a flit moves on a side when its val and rdy are both high in
// the same cycle; val never depends on rdy, and the source holds data stable
// while val is high and rdy is low.
module udp_tx_lb_multi
    import udp_tx_lb_pkg::*;
#(
    parameter int NOC_DATA_W  = 512,
    parameter int XY_W        = 8,
    parameter int NUM_DSTS    = 4,
    parameter int DST_X_LSB   = 0,
    parameter int DST_Y_LSB   = 8,
    parameter int MSG_LEN_LSB = 16,
    parameter int MSG_LEN_W   = 8,
    parameter int BASE_X      = 1,
    parameter int BASE_Y      = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_udp_tx_lb_val,
    input  logic [NOC_DATA_W-1:0]       src_udp_tx_lb_data,
    output logic                        udp_tx_lb_src_rdy,
    output logic                        udp_tx_lb_dst_val,
    output logic [NOC_DATA_W-1:0]       udp_tx_lb_dst_data,
    input  logic                        dst_udp_tx_lb_rdy,
    input  logic                        cfg_wr_val,
    input  logic [$clog2(NUM_DSTS)-1:0] cfg_wr_idx,
    input  logic [XY_W-1:0]             cfg_wr_x,
    input  logic [XY_W-1:0]             cfg_wr_y,
    input  logic [$clog2(NUM_DSTS):0]   cfg_num_active,
    output logic                        lb_busy
`ifdef UDP_TX_LB_MULTI_STATS_EN
    ,
    output logic [NUM_DSTS*32-1:0]      lb_pkt_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_DSTS);

    lb_state_e            state_q;
    lb_state_e            state_d;
    logic [MSG_LEN_W-1:0] body_cnt;
    logic [MSG_LEN_W-1:0] msg_len;
    logic                 xfer;
    logic                 hdr_xfer;
    logic                 body_xfer;
    logic [XY_W-1:0]      sel_x;
    logic [XY_W-1:0]      sel_y;
    logic [IDX_W-1:0]     sel_idx;

    assign udp_tx_lb_dst_val = src_udp_tx_lb_val;
    assign udp_tx_lb_src_rdy = dst_udp_tx_lb_rdy;

    assign xfer      = src_udp_tx_lb_val && dst_udp_tx_lb_rdy;
    assign hdr_xfer  = xfer && (state_q == HDR);
    assign body_xfer = xfer && (state_q == BODY);
    assign msg_len   = src_udp_tx_lb_data[MSG_LEN_LSB +: MSG_LEN_W];

    udp_tx_lb_rr_sel #(
        .NUM_DSTS (NUM_DSTS),
        .XY_W     (XY_W),
        .BASE_X   (BASE_X),
        .BASE_Y   (BASE_Y)
    ) u_rr_sel (
        .clk            (clk),
        .rst            (rst),
        .adv            (hdr_xfer),
        .cfg_wr_val     (cfg_wr_val),
        .cfg_wr_idx     (cfg_wr_idx),
        .cfg_wr_x       (cfg_wr_x),
        .cfg_wr_y       (cfg_wr_y),
        .cfg_num_active (cfg_num_active),
        .sel_x          (sel_x),
        .sel_y          (sel_y),
        .sel_idx        (sel_idx)
    );

    // Message framing state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a non-empty header opens a body, the last body flit closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR:     if (hdr_xfer && (msg_len != '0)) state_d = BODY;
            BODY:    if (body_xfer && (body_cnt == MSG_LEN_W'(1))) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    // Outputs: headers get the selected destination, body flits pass as-is.
    always_comb begin
        udp_tx_lb_dst_data = src_udp_tx_lb_data;
        lb_busy            = 1'b0;
        case (state_q)
            HDR: begin
                udp_tx_lb_dst_data[DST_X_LSB +: XY_W] = sel_x;
                udp_tx_lb_dst_data[DST_Y_LSB +: XY_W] = sel_y;
            end
            BODY:    lb_busy = 1'b1;
            default: lb_busy = 1'b0;
        endcase
    end

    // Remaining body flits of the message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            body_cnt <= '0;
        end else if (hdr_xfer) begin
            body_cnt <= msg_len;
        end else if (body_xfer) begin
            body_cnt <= body_cnt - 1'b1;
        end
    end

`ifdef UDP_TX_LB_MULTI_STATS_EN
    logic [31:0] pkt_cnt [NUM_DSTS];

    // Per-destination header counters; reprogramming an entry restarts its count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DSTS; i++) pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_DSTS; i++) begin
                if (cfg_wr_val && (cfg_wr_idx == IDX_W'(i))) begin
                    pkt_cnt[i] <= '0;
                end else if (hdr_xfer && (sel_idx == IDX_W'(i))) begin
                    pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_DSTS; g++) begin : g_cnt
        assign lb_pkt_cnt[32*g +: 32] = pkt_cnt[g];
    end
`else
    logic sel_idx_unused;
    assign sel_idx_unused = ^sel_idx;
`endif

endmodule

// File: tb/tb_udp_tx_lb_multi.sv
// Self-checking bench for udp_tx_lb_multi: a vector table for the plain
// round-robin traffic plus hand-written sequences for stalls, table writes,
// active-count changes and reset mid-message.
module tb_udp_tx_lb_multi;
    import udp_tx_lb_pkg::*;

    localparam int W  = 512;
    localparam int XY = 8;
    localparam int ND = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_val;
    logic [W-1:0]  src_data;
    logic          src_rdy;
    logic          dst_val;
    logic [W-1:0]  dst_data;
    logic          dst_rdy;
    logic          cfg_wr_val;
    logic [IW-1:0] cfg_wr_idx;
    logic [XY-1:0] cfg_wr_x;
    logic [XY-1:0] cfg_wr_y;
    logic [IW:0]   cfg_num_active;
    logic          lb_busy;
`ifdef UDP_TX_LB_MULTI_STATS_EN
    logic [ND*32-1:0] lb_pkt_cnt;
`endif

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [IW:0]   na;
        logic          hdr;
        logic [7:0]    len;
        lb_dst_entry_t dst;
        logic          busy;
    } vec_t;

    vec_t vecs[$];

    udp_tx_lb_multi dut (
        .clk                (clk),
        .rst                (rst),
        .src_udp_tx_lb_val  (src_val),
        .src_udp_tx_lb_data (src_data),
        .udp_tx_lb_src_rdy  (src_rdy),
        .udp_tx_lb_dst_val  (dst_val),
        .udp_tx_lb_dst_data (dst_data),
        .dst_udp_tx_lb_rdy  (dst_rdy),
        .cfg_wr_val         (cfg_wr_val),
        .cfg_wr_idx         (cfg_wr_idx),
        .cfg_wr_x           (cfg_wr_x),
        .cfg_wr_y           (cfg_wr_y),
        .cfg_num_active     (cfg_num_active),
        .lb_busy            (lb_busy)
`ifdef UDP_TX_LB_MULTI_STATS_EN
        ,
        .lb_pkt_cnt         (lb_pkt_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_flit();
        logic [W-1:0] f;
        for (int i = 0; i < W/32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic logic [W-1:0] mk_hdr(input logic [7:0] len);
        logic [W-1:0] f;
        f = rand_flit();
        f[16 +: 8] = len;
        return f;
    endfunction

    function automatic vec_t mk_vec(input logic [IW:0] na, input logic hdr, input logic [7:0] len,
                                    input logic [7:0] x, input logic [7:0] y, input logic busy);
        vec_t v;
        v.na = na; v.hdr = hdr; v.len = len; v.dst.x = x; v.dst.y = y; v.busy = busy;
        return v;
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic drive_cycle(input logic val, input logic [W-1:0] flit, input logic rdy,
                               input logic hdr, input logic [XY-1:0] ex, input logic [XY-1:0] ey,
                               input logic exp_busy, input string name);
        logic [W-1:0] e;
        src_val  = val;
        src_data = flit;
        dst_rdy  = rdy;
        if (val && rdy) begin
            e = flit;
            if (hdr) begin
                e[0 +: XY] = ex;
                e[8 +: XY] = ey;
            end
            exp_q.push_back(e);
        end
        @(negedge clk);
        check({name, " dst_val"}, W'(dst_val), W'(val));
        check({name, " src_rdy"}, W'(src_rdy), W'(rdy));
        check({name, " lb_busy"}, W'(lb_busy), W'(exp_busy));
        if (dst_val && dst_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s data: unexpected transfer %0h", name, dst_data);
            end else begin
                check({name, " data"}, dst_data, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cfg_wr_val = 1'b0;
    endtask

    task automatic hdr_cycle(input logic [7:0] len, input logic [XY-1:0] ex, input logic [XY-1:0] ey,
                             input string name);
        drive_cycle(1'b1, mk_hdr(len), 1'b1, 1'b1, ex, ey, 1'b0, name);
    endtask

    task automatic cfg_set(input logic [IW-1:0] idx, input logic [XY-1:0] x, input logic [XY-1:0] y);
        cfg_wr_val = 1'b1;
        cfg_wr_idx = idx;
        cfg_wr_x   = x;
        cfg_wr_y   = y;
    endtask

    initial begin
        logic [W-1:0] f;
        rst = 1'b1; src_val = 1'b0; src_data = '0; dst_rdy = 1'b0;
        cfg_wr_val = 1'b0; cfg_wr_idx = '0; cfg_wr_x = '0; cfg_wr_y = '0; cfg_num_active = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        // Reset state and combinational val/rdy follow-through during reset.
        check("reset lb_busy", W'(lb_busy), W'(0));
        check("reset dst_val idle", W'(dst_val), W'(0));
        src_val = 1'b1; dst_rdy = 1'b1;
        #1;
        check("reset dst_val follows", W'(dst_val), W'(1));
        check("reset src_rdy follows", W'(src_rdy), W'(1));
        src_val = 1'b0; dst_rdy = 1'b0;
`ifdef UDP_TX_LB_MULTI_STATS_EN
        check("reset pkt_cnt", W'(lb_pkt_cnt), W'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four 2-body messages over the default table, then five header-only on two entries.
        for (int m = 0; m < 4; m++) begin
            vecs.push_back(mk_vec(3'd4, 1'b1, 8'd2, 8'(m + 1), 8'd0, 1'b0));
            vecs.push_back(mk_vec(3'd4, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1));
            vecs.push_back(mk_vec(3'd4, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1));
        end
        vecs.push_back(mk_vec(3'd2, 1'b1, 8'd0, 8'd1, 8'd0, 1'b0));
        vecs.push_back(mk_vec(3'd2, 1'b1, 8'd0, 8'd2, 8'd0, 1'b0));
        vecs.push_back(mk_vec(3'd2, 1'b1, 8'd0, 8'd1, 8'd0, 1'b0));
        vecs.push_back(mk_vec(3'd2, 1'b1, 8'd0, 8'd2, 8'd0, 1'b0));
        vecs.push_back(mk_vec(3'd2, 1'b1, 8'd0, 8'd1, 8'd0, 1'b0));
        foreach (vecs[i]) begin
            cfg_num_active = vecs[i].na;
            f = vecs[i].hdr ? mk_hdr(vecs[i].len) : rand_flit();
            drive_cycle(1'b1, f, 1'b1, vecs[i].hdr, vecs[i].dst.x, vecs[i].dst.y, vecs[i].busy,
                        $sformatf("vec%0d", i));
        end

        // 3-body message with the sink toggling ready; pointer now at entry 1.
        hdr_cycle(8'd3, 8'd2, 8'd0, "stall hdr");
        for (int b = 0; b < 3; b++) begin
            f = rand_flit();
            drive_cycle(1'b1, f, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, $sformatf("stall b%0d wait", b));
            drive_cycle(1'b1, f, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, $sformatf("stall b%0d go", b));
        end
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, "stall back to hdr");
        hdr_cycle(8'd0, 8'd1, 8'd0, "stall next hdr");

        // Rewrite entry 1 while its message body is in flight.
        hdr_cycle(8'd2, 8'd2, 8'd0, "wr hdr e1");
        cfg_set(2'd1, 8'd9, 8'd5);
        drive_cycle(1'b1, rand_flit(), 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, "wr body0");
        drive_cycle(1'b1, rand_flit(), 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, "wr body1");
        hdr_cycle(8'd0, 8'd1, 8'd0, "wr hdr e0");
        hdr_cycle(8'd0, 8'd9, 8'd5, "wr hdr e1 new");
        // Write landing in the same cycle as the header that uses it.
        cfg_set(2'd0, 8'd7, 8'd7);
        hdr_cycle(8'd0, 8'd1, 8'd0, "same-cycle wr old");
        hdr_cycle(8'd0, 8'd9, 8'd5, "same-cycle e1");
        hdr_cycle(8'd0, 8'd7, 8'd7, "same-cycle e0 new");

        // Shrink the active count while the pointer sits on entry 3.
        cfg_num_active = 3'd4;
        hdr_cycle(8'd0, 8'd9, 8'd5, "shrink e1");
        hdr_cycle(8'd0, 8'd3, 8'd0, "shrink e2");
        cfg_num_active = 3'd2;
        hdr_cycle(8'd0, 8'd7, 8'd7, "shrink e0");
        hdr_cycle(8'd0, 8'd9, 8'd5, "shrink e1 after");

        // Reset after the first of four body flits.
        cfg_num_active = 3'd4;
        hdr_cycle(8'd4, 8'd7, 8'd7, "rst hdr");
        drive_cycle(1'b1, rand_flit(), 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, "rst body0");
        src_val = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-rst lb_busy", W'(lb_busy), W'(0));
`ifdef UDP_TX_LB_MULTI_STATS_EN
        check("post-rst pkt_cnt", W'(lb_pkt_cnt), W'(0));
`endif
        hdr_cycle(8'd0, 8'd1, 8'd0, "post-rst hdr e0");
        hdr_cycle(8'd1, 8'd2, 8'd0, "post-rst hdr e1");
        drive_cycle(1'b1, rand_flit(), 1'b1, 1'b0, 8'd0, 8'd0, 1'b1, "post-rst body");
`ifdef UDP_TX_LB_MULTI_STATS_EN
        check("pkt_cnt counts", W'(lb_pkt_cnt), W'({32'd0, 32'd0, 32'd1, 32'd1}));
`endif

        check("scoreboard drained", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
